// File: rtl/local_port_cycle_ctrl_pkg.sv
// Shared types and constants for the local-port bus cycle controller:
// FSM states, DSACK termination codes, 68040 SIZ encodings and the default timeout.
package local_port_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [1:0] DSACK_IDLE = 2'b11;
  localparam logic [1:0] DSACK_LONG = 2'b00;
  localparam logic [1:0] DSACK_WORD = 2'b01;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam int TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/local_port_cycle_ctrl_lane_decode.sv
// Combinational byte-lane decode: SIZ/A/PORT16 to the active-low nBEN pattern.
// Lane 3 is D31:24; a 16-bit port lives on D31:16 so lanes 1:0 stay off there.
module port_lane_decode
  import local_port_cycle_ctrl_pkg::*;
(
  input  logic [1:0] i_siz,
  input  logic [1:0] i_a,
  input  logic       i_port16,
  output logic [3:0] o_nben
);

  always_comb begin
    o_nben = 4'b0000;
    if (i_port16) begin
      case (i_siz)
        SIZ_BYTE: o_nben = i_a[0] ? 4'b1011 : 4'b0111;
        default:  o_nben = 4'b0011;
      endcase
    end else begin
      case (i_siz)
        SIZ_BYTE: o_nben = ~(4'b1000 >> i_a);
        SIZ_WORD: o_nben = i_a[1] ? 4'b1100 : 4'b0011;
        default:  o_nben = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/local_port_cycle_ctrl.sv
// Local-port bus cycle controller: turns a sampled nTS/nCS request into
// registered strobes, byte enables and a DSACK or bus-error termination.
module local_port_cycle_ctrl
  import local_port_cycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       CLK40,
  input  logic       RESET,
  input  logic       nTS,
  input  logic       nCS,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic [1:0] A,
  input  logic       PORT16,
  input  logic [3:0] WAIT_CFG,
  input  logic       nWAIT,
  output logic [1:0] DSACK,
  output logic       nAS,
  output logic       nDS,
  output logic [3:0] nBEN,
  output logic       nBERR
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic [3:0]      r_wait_cnt;
  logic [TO_W-1:0] r_to_cnt;

  logic            r_rnw;
  logic [1:0]      r_siz;
  logic [1:0]      r_a;
  logic            r_port16;
  logic [3:0]      r_wait_cfg;

  logic            w_start;
  logic [3:0]      w_lanes;

  assign w_start = (r_state == ST_IDLE) && !nTS && !nCS;

  port_lane_decode u_lane_decode (
    .i_siz    (r_siz),
    .i_a      (r_a),
    .i_port16 (r_port16),
    .o_nben   (w_lanes)
  );

  // Transfer attributes are captured only on an accepted start; no reset needed.
  always_ff @(posedge CLK40) begin
    if (w_start) begin
      r_rnw      <= RnW;
      r_siz      <= SIZ;
      r_a        <= A;
      r_port16   <= PORT16;
      r_wait_cfg <= WAIT_CFG;
    end
  end

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
      DSACK      <= DSACK_IDLE;
      nAS        <= 1'b1;
      nDS        <= 1'b1;
      nBEN       <= 4'b1111;
      nBERR      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          nAS        <= 1'b0;
          nBEN       <= w_lanes;
          if (r_rnw) nDS <= 1'b0;
          r_wait_cnt <= r_wait_cfg;
          r_to_cnt   <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          nDS <= 1'b0;
          if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 4'd1;
          // Fixed waits must expire and the target must release nWAIT before DSACK.
          if (r_wait_cnt == '0 && nWAIT) begin
            DSACK   <= r_port16 ? DSACK_WORD : DSACK_LONG;
            r_state <= ST_ACK;
          end else if (!nWAIT) begin
            if (r_to_cnt == TO_LAST) begin
              nBERR   <= 1'b0;
              r_state <= ST_ACK;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
        end
        ST_ACK: begin
          DSACK   <= DSACK_IDLE;
          nBERR   <= 1'b1;
          nAS     <= 1'b1;
          nDS     <= 1'b1;
          nBEN    <= 4'b1111;
          r_state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_local_port_cycle_ctrl.sv
// Directed bench for local_port_cycle_ctrl: per-scenario tasks with inline checks.
module tb_local_port_cycle_ctrl;

  logic       CLK40;
  logic       RESET;
  logic       nTS;
  logic       nCS;
  logic       RnW;
  logic [1:0] SIZ;
  logic [1:0] A;
  logic       PORT16;
  logic [3:0] WAIT_CFG;
  logic       nWAIT;
  logic [1:0] DSACK;
  logic       nAS;
  logic       nDS;
  logic [3:0] nBEN;
  logic       nBERR;

  int checks;
  int failures;

  localparam logic [8:0] IDLE_VEC = 9'b11_1_1_1_1111;

  local_port_cycle_ctrl #(.TIMEOUT_CYCLES(256)) dut (
    .CLK40    (CLK40),
    .RESET    (RESET),
    .nTS      (nTS),
    .nCS      (nCS),
    .RnW      (RnW),
    .SIZ      (SIZ),
    .A        (A),
    .PORT16   (PORT16),
    .WAIT_CFG (WAIT_CFG),
    .nWAIT    (nWAIT),
    .DSACK    (DSACK),
    .nAS      (nAS),
    .nDS      (nDS),
    .nBEN     (nBEN),
    .nBERR    (nBERR)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  logic [8:0] obs;
  assign obs = {DSACK, nAS, nDS, nBERR, nBEN};

  // Expected outputs "off" clocks after the sampling edge; DSACK is visible at off = 2 + WAIT_CFG.
  function automatic logic [8:0] exp_vec(int off, int ack, bit rnw, logic [1:0] code, logic [3:0] lanes);
    logic       nas, nds;
    logic [1:0] ds;
    logic [3:0] ben;
    nas = !(off >= 1 && off <= ack);
    nds = rnw ? nas : !(off >= 2 && off <= ack);
    ben = nas ? 4'hF : lanes;
    ds  = (off == ack) ? code : 2'b11;
    return {ds, nas, nds, 1'b1, ben};
  endfunction

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  // Presents one nTS/nCS request; returns 1 ns after the sampling edge.
  task automatic issue(input bit rnw, input logic [1:0] siz, input logic [1:0] a,
                       input bit p16, input logic [3:0] wcfg);
    RnW = rnw; SIZ = siz; A = a; PORT16 = p16; WAIT_CFG = wcfg;
    nTS = 1'b0; nCS = 1'b0;
    tick();
    nTS = 1'b1; nCS = 1'b1;
    RnW = 1'b0; SIZ = 2'b11; A = 2'b00; PORT16 = 1'b0; WAIT_CFG = 4'hF;
  endtask

  task automatic test_reset();
    RESET = 1'b1; nTS = 1'b1; nCS = 1'b1; nWAIT = 1'b1;
    RnW = 1'b0; SIZ = 2'b00; A = 2'b00; PORT16 = 1'b0; WAIT_CFG = 4'd0;
    tick(); tick();
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs, IDLE_VEC);
    end
    RESET = 1'b0;
  endtask

  task automatic test_read32_long();
    logic [8:0] e;
    issue(1'b1, 2'b00, 2'b00, 1'b0, 4'd0);
    for (int off = 0; off <= 4; off++) begin
      e = exp_vec(off, 2, 1'b1, 2'b00, 4'b0000);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL read32_long off=%0d got=%b exp=%b", off, obs, e);
      end
      if (off < 4) tick();
    end
  endtask

  task automatic test_back_to_back_write16();
    logic [8:0]  e;
    logic [1:0]  addr [2];
    addr[0] = 2'b00;
    addr[1] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, 2'b00, addr[k], 1'b1, 4'd3);
      for (int off = 0; off <= 7; off++) begin
        e = exp_vec(off, 5, 1'b0, 2'b01, 4'b0011);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL write16_word%0d off=%0d got=%b exp=%b", k, off, obs, e);
        end
        if (off < 7) tick();
      end
    end
  endtask

  task automatic test_lanes();
    logic [3:0] tbl [2][4];
    logic [8:0] e;
    logic [1:0] siz2 [3];
    logic [1:0] a2   [3];
    logic [3:0] ln2  [3];
    tbl[0] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    tbl[1] = '{4'b0111, 4'b1011, 4'b0111, 4'b1011};
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 4; a++) begin
        issue(1'b1, 2'b01, 2'(a), p[0], 4'd0);
        for (int off = 0; off <= 4; off++) begin
          e = exp_vec(off, 2, 1'b1, p[0] ? 2'b01 : 2'b00, tbl[p][a]);
          if (off == 2) begin
            checks++;
            if (obs !== e) begin
              failures++;
              $display("FAIL byte_lane p16=%0d a=%0d got=%b exp=%b", p, a, obs, e);
            end
          end
          if (off < 4) tick();
        end
      end
    end
    siz2 = '{2'b10, 2'b10, 2'b11};
    a2   = '{2'b00, 2'b10, 2'b00};
    ln2  = '{4'b0011, 4'b1100, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, siz2[i], a2[i], 1'b0, 4'd0);
      for (int off = 0; off <= 4; off++) begin
        e = exp_vec(off, 2, 1'b1, 2'b00, ln2[i]);
        if (off == 1) begin
          checks++;
          if (obs !== e) begin
            failures++;
            $display("FAIL wide_lane case=%0d got=%b exp=%b", i, obs, e);
          end
        end
        if (off < 4) tick();
      end
    end
  endtask

  task automatic test_timeout();
    int hit;
    bit dsack_seen;
    hit = -1;
    dsack_seen = 1'b0;
    nWAIT = 1'b0;
    issue(1'b1, 2'b00, 2'b00, 1'b0, 4'd0);
    for (int n = 1; n <= 400 && hit < 0; n++) begin
      tick();
      if (DSACK !== 2'b11) dsack_seen = 1'b1;
      if (nBERR === 1'b0) hit = n;
    end
    checks++;
    if (hit != 257) begin
      failures++;
      $display("FAIL timeout_berr_clock got=%0d exp=257", hit);
    end
    checks++;
    if (dsack_seen || nAS !== 1'b0) begin
      failures++;
      $display("FAIL timeout_term got dsack_seen=%0d nAS=%b exp dsack_seen=0 nAS=0", dsack_seen, nAS);
    end
    tick();
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL timeout_berr_one_clock got=%b exp=%b", obs, IDLE_VEC);
    end
    for (int n = 0; n < 40; n++) tick();
    nWAIT = 1'b1;
    tick();
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL timeout_idle got=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_reset_midcycle();
    logic [8:0] e;
    issue(1'b0, 2'b00, 2'b00, 1'b0, 4'd5);
    tick(); tick(); tick();
    checks++;
    if (nAS !== 1'b0 || nDS !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_strobes got nAS=%b nDS=%b exp nAS=0 nDS=0", nAS, nDS);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs, IDLE_VEC);
    end
    #1 RESET = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, IDLE_VEC);
    end
    issue(1'b1, 2'b00, 2'b00, 1'b1, 4'd0);
    tick(); tick();
    e = exp_vec(2, 2, 1'b1, 2'b01, 4'b0011);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL post_reset_cycle got=%b exp=%b", obs, e);
    end
    tick(); tick();
  endtask

  task automatic test_ignored_nts();
    logic [8:0] e;
    nTS = 1'b0; nCS = 1'b1;
    tick();
    nTS = 1'b1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs !== IDLE_VEC) begin
        failures++;
        $display("FAIL ncs_high_ignored n=%0d got=%b exp=%b", n, obs, IDLE_VEC);
      end
      tick();
    end
    issue(1'b1, 2'b00, 2'b00, 1'b0, 4'd2);
    for (int off = 0; off <= 10; off++) begin
      e = exp_vec(off, 4, 1'b1, 2'b00, 4'b0000);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL nts_in_ack_ignored off=%0d got=%b exp=%b", off, obs, e);
      end
      if (off == 4) begin
        RnW = 1'b1; SIZ = 2'b00; PORT16 = 1'b0; WAIT_CFG = 4'd0;
        nTS = 1'b0; nCS = 1'b0;
      end else begin
        nTS = 1'b1; nCS = 1'b1;
      end
      if (off < 10) tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_read32_long();
    test_back_to_back_write16();
    test_lanes();
    test_timeout();
    test_reset_midcycle();
    test_ignored_nts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
